// File: rtl/fwd_hazard_tracker.sv
// Forwarding/hazard tracker: shifts in-flight writer records per post-ID stage, produces
// registered operand forward selects, a combinational load-use stall and a stall counter.
module fwd_hazard_tracker #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } slot_t;

    slot_t                     slot [1:FWD_STAGES];
    slot_t                     new_slot;
    logic [NUM_SRC*SEL_W-1:0]  sel_d;
    logic [NUM_SRC-1:0]        hazard;
    logic                      accept;

    // Scan oldest to youngest so the youngest match overwrites and wins.
    always_comb begin
        sel_d  = '0;
        hazard = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
                if (slot[k].vld && id_rs_used[i] && (|id_rs[i*REG_AW +: REG_AW]) &&
                    (id_rs[i*REG_AW +: REG_AW] == slot[k].rd)) begin
                    sel_d[i*SEL_W +: SEL_W] = SEL_W'(k);
                    hazard[i]               = slot[k].is_load && (k <= LOAD_LAT);
                end
            end
        end
    end

    assign stall  = id_valid & ~flush & (|hazard);
    assign accept = id_valid & ~stall & ~flush;

    always_comb begin
        new_slot         = '0;
        new_slot.vld     = accept & id_reg_write & (|id_rd);
        new_slot.rd      = id_rd;
        new_slot.is_load = id_is_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                slot[k] <= '0;
            end
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int unsigned k = 2; k <= FWD_STAGES; k++) begin
                slot[k] <= slot[k-1];
            end
            slot[1] <= new_slot;
            fwd_sel <= accept ? sel_d : '0;
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Randomized bench for two fwd_hazard_tracker configurations against an in-flight-writer model.
module tb_fwd_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid, id_reg_write, id_is_load;
    logic [14:0] id_rs;
    logic [2:0]  id_rs_used;
    logic [4:0]  id_rd;

    logic [3:0]  sel_a;
    logic        stall_a;
    logic [15:0] cnt_a;
    logic [8:0]  sel_b;
    logic        stall_b;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    fwd_hazard_tracker #(
        .REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs[9:0]), .id_rs_used(id_rs_used[1:0]), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .fwd_sel(sel_a), .stall(stall_a), .stall_cnt(cnt_a)
    );

    fwd_hazard_tracker #(
        .REG_AW(5), .NUM_SRC(3), .FWD_STAGES(4), .LOAD_LAT(2), .CNT_W(3)
    ) dut_b (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .fwd_sel(sel_b), .stall(stall_b), .stall_cnt(cnt_b)
    );

    // Configuration table of the two instances: stages, load latency, operands, counter max.
    int FS [2] = '{2, 4};
    int LL [2] = '{1, 2};
    int NS [2] = '{2, 3};
    int CM [2] = '{65535, 7};

    // Model: in-flight writers by age (index = stages past ID), registered selects, counter.
    int mvld [2][5];
    int mrd  [2][5];
    int mld  [2][5];
    int msel [2][3];
    int mcnt [2];
    int esel [2][3];
    int est  [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_model();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 5; k++) begin
                mvld[p][k] = 0; mrd[p][k] = 0; mld[p][k] = 0;
            end
            for (int i = 0; i < 3; i++) msel[p][i] = 0;
            mcnt[p] = 0;
        end
    endfunction

    function automatic void model_eval();
        for (int p = 0; p < 2; p++) begin
            int haz = 0;
            for (int i = 0; i < 3; i++) begin
                int rs = int'(id_rs[5*i +: 5]);
                esel[p][i] = 0;
                if (i < NS[p] && id_rs_used[i] && rs != 0) begin
                    for (int k = 1; k <= FS[p]; k++) begin
                        if (mvld[p][k] != 0 && mrd[p][k] == rs) begin
                            esel[p][i] = k;
                            if (mld[p][k] != 0 && k <= LL[p]) haz = 1;
                            break;
                        end
                    end
                end
            end
            est[p] = (id_valid && !flush && haz != 0) ? 1 : 0;
        end
    endfunction

    function automatic void model_step();
        if (hold) return;
        for (int p = 0; p < 2; p++) begin
            int acc = (id_valid && !flush && est[p] == 0) ? 1 : 0;
            for (int k = FS[p]; k >= 2; k--) begin
                mvld[p][k] = mvld[p][k-1]; mrd[p][k] = mrd[p][k-1]; mld[p][k] = mld[p][k-1];
            end
            mvld[p][1] = (acc != 0 && id_reg_write && id_rd != 0) ? 1 : 0;
            mrd[p][1]  = int'(id_rd);
            mld[p][1]  = int'(id_is_load);
            for (int i = 0; i < 3; i++) msel[p][i] = (acc != 0) ? esel[p][i] : 0;
            if (est[p] != 0 && mcnt[p] < CM[p]) mcnt[p]++;
        end
    endfunction

    task automatic check_outputs();
        check_val("stall_a", int'(stall_a), est[0]);
        check_val("stall_b", int'(stall_b), est[1]);
        check_val("cnt_a", int'(cnt_a), mcnt[0]);
        check_val("cnt_b", int'(cnt_b), mcnt[1]);
        for (int i = 0; i < 2; i++) check_val($sformatf("sel_a[%0d]", i), int'(sel_a[2*i +: 2]), msel[0][i]);
        for (int i = 0; i < 3; i++) check_val($sformatf("sel_b[%0d]", i), int'(sel_b[3*i +: 3]), msel[1][i]);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_reg_write = 1'b0;
        id_is_load = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        clear_model();
        #12;
        model_eval();
        check_outputs();
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            id_valid     = ($urandom_range(0, 9) < 8);
            id_reg_write = ($urandom_range(0, 9) < 7);
            id_is_load   = ($urandom_range(0, 9) < 4);
            id_rd        = 5'($urandom_range(0, 3));
            for (int i = 0; i < 3; i++) begin
                id_rs[5*i +: 5] = 5'($urandom_range(0, 3));
                id_rs_used[i]   = ($urandom_range(0, 9) < 8);
            end
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            model_eval();
            check_outputs();
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b1;
                #1;
                clear_model();
                model_eval();
                check_outputs();
                reset = 1'b0;
            end
            @(posedge clk);
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
